// File: rtl/core_mem_access.sv
// core_mem_access -- memory stage of the RISC-V pipeline.
//
// This stage sits between execute and core_write. It issues one aligned
// load/store transaction at a time on the data bus. It builds the byte-lane
// selects and replicates store data across the lanes. It stalls upstream
// (o_ready=0) while a transaction is in flight. The raw read word and the
// sideband are registered for core_write, which does the byte/half extraction.
//
// Parameters
//   TIMEOUT      max BUS-state cycles without ack before abort (0 = never)
// Ports
//   i_clk, i_reset            clock / asynchronous active-high reset
//   i_valid, o_ready          upstream handshake (o_ready only in IDLE)
//   i_mem_read, i_mem_write   load / store (store wins if both set)
//   i_alu_result, i_store_data, i_funct3, i_res_src, i_pc_p4, i_rd
//                             instruction fields from execute
//   o_bus_req/we/addr/sel/wdata, i_bus_ack/err/rdata
//                             data-bus master interface
//   o_valid                   one-cycle result strobe to core_write
//   o_data, o_alu_result, o_pc_p4, o_funct3, o_res_src, o_rd, o_fault
//                             registered results; o_fault 01 misaligned,
//                             10 bus error, 11 timeout
module core_mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_res_src,
  input  logic [29:0] i_pc_p4,
  input  logic [4:0]  i_rd,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [29:0] o_bus_addr,
  output logic [3:0]  o_bus_sel,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  input  logic [31:0] i_bus_rdata,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic [31:0] o_alu_result,
  output logic [29:0] o_pc_p4,
  output logic [2:0]  o_funct3,
  output logic [1:0]  o_res_src,
  output logic [4:0]  o_rd,
  output logic [1:0]  o_fault
);

  typedef enum logic {
    S_IDLE,
    S_BUS
  } state_t;

  state_t state, state_nx;

  logic [31:0] wait_cnt;

  // Sideband of the in-flight access. The visible outputs must hold the
  // previous result until this access terminates, so it is parked here.
  logic [31:0] pend_alu;
  logic [29:0] pend_pc;
  logic [2:0]  pend_f3;
  logic [1:0]  pend_res;
  logic [4:0]  pend_rd;
  logic        pend_store;

  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic        timed_out;
  logic        bus_term;
  logic [3:0]  sel_nx;
  logic [31:0] wdata_nx;

  assign o_ready = (state == S_IDLE);

  always_comb begin
    accept     = i_valid && (state == S_IDLE);
    is_mem     = i_mem_read || i_mem_write;
    misaligned = 1'b0;
    sel_nx     = 4'b1111;
    wdata_nx   = i_store_data;

    unique case (i_funct3[1:0])
      2'b00: begin
        sel_nx   = 4'b0001 << i_alu_result[1:0];
        wdata_nx = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        misaligned = i_alu_result[0];
        sel_nx     = i_alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_nx   = {2{i_store_data[15:0]}};
      end
      default: begin
        misaligned = (i_alu_result[1:0] != 2'b00);
      end
    endcase

    // Loads fetch the whole word; lane extraction happens downstream.
    if (!i_mem_write) begin
      sel_nx   = 4'b1111;
      wdata_nx = '0;
    end

    // An ack on the final allowed cycle still counts as a normal completion.
    timed_out = (TIMEOUT != 0) && (wait_cnt == TIMEOUT - 1) &&
                !i_bus_ack && !i_bus_err;
    bus_term  = (state == S_BUS) && (i_bus_ack || i_bus_err || timed_out);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept && is_mem && !misaligned) state_nx = S_BUS;
      S_BUS:  if (bus_term) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt     <= '0;
      pend_alu     <= '0;
      pend_pc      <= '0;
      pend_f3      <= '0;
      pend_res     <= '0;
      pend_rd      <= '0;
      pend_store   <= 1'b0;
      o_bus_req    <= 1'b0;
      o_bus_we     <= 1'b0;
      o_bus_addr   <= '0;
      o_bus_sel    <= '0;
      o_bus_wdata  <= '0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_alu_result <= '0;
      o_pc_p4      <= '0;
      o_funct3     <= '0;
      o_res_src    <= '0;
      o_rd         <= '0;
      o_fault      <= '0;
    end else begin
      o_valid <= 1'b0;

      if (accept) begin
        if (!is_mem || misaligned) begin
          o_valid      <= 1'b1;
          o_data       <= '0;
          o_alu_result <= i_alu_result;
          o_pc_p4      <= i_pc_p4;
          o_funct3     <= i_funct3;
          o_res_src    <= i_res_src;
          o_rd         <= misaligned ? 5'd0 : i_rd;
          o_fault      <= misaligned ? 2'b01 : 2'b00;
        end else begin
          pend_alu    <= i_alu_result;
          pend_pc     <= i_pc_p4;
          pend_f3     <= i_funct3;
          pend_res    <= i_res_src;
          pend_rd     <= i_rd;
          pend_store  <= i_mem_write;
          wait_cnt    <= '0;
          o_bus_req   <= 1'b1;
          o_bus_we    <= i_mem_write;
          o_bus_addr  <= i_alu_result[31:2];
          o_bus_sel   <= sel_nx;
          o_bus_wdata <= wdata_nx;
        end
      end

      if (state == S_BUS) begin
        if (bus_term) begin
          o_bus_req    <= 1'b0;
          o_bus_we     <= 1'b0;
          o_bus_addr   <= '0;
          o_bus_sel    <= '0;
          o_bus_wdata  <= '0;
          o_valid      <= 1'b1;
          o_alu_result <= pend_alu;
          o_pc_p4      <= pend_pc;
          o_funct3     <= pend_f3;
          o_res_src    <= pend_res;
          if (i_bus_err) begin
            o_fault <= 2'b10;
            o_rd    <= '0;
            o_data  <= '0;
          end else if (i_bus_ack) begin
            o_fault <= 2'b00;
            o_rd    <= pend_store ? 5'd0 : pend_rd;
            o_data  <= pend_store ? 32'd0 : i_bus_rdata;
          end else begin
            o_fault <= 2'b11;
            o_rd    <= '0;
            o_data  <= '0;
          end
        end else begin
          wait_cnt <= wait_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_mem_access.sv
module tb_core_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_mem_read, i_mem_write;
  logic [31:0] i_alu_result, i_store_data;
  logic [2:0]  i_funct3;
  logic [1:0]  i_res_src;
  logic [29:0] i_pc_p4;
  logic [4:0]  i_rd;
  logic        o_ready, o_bus_req, o_bus_we;
  logic [29:0] o_bus_addr;
  logic [3:0]  o_bus_sel;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack, i_bus_err;
  logic [31:0] i_bus_rdata;
  logic        o_valid;
  logic [31:0] o_data, o_alu_result;
  logic [29:0] o_pc_p4;
  logic [2:0]  o_funct3;
  logic [1:0]  o_res_src;
  logic [4:0]  o_rd;
  logic [1:0]  o_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_mem_access #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_alu_result(i_alu_result), .i_store_data(i_store_data),
    .i_funct3(i_funct3), .i_res_src(i_res_src), .i_pc_p4(i_pc_p4), .i_rd(i_rd),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_sel(o_bus_sel), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_err(i_bus_err), .i_bus_rdata(i_bus_rdata),
    .o_valid(o_valid), .o_data(o_data), .o_alu_result(o_alu_result),
    .o_pc_p4(o_pc_p4), .o_funct3(o_funct3), .o_res_src(o_res_src),
    .o_rd(o_rd), .o_fault(o_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd_op, input logic wr_op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [29:0] pc);
    i_valid      = 1'b1;
    i_mem_read   = rd_op;
    i_mem_write  = wr_op;
    i_alu_result = addr;
    i_store_data = sd;
    i_funct3     = f3;
    i_rd         = rd;
    i_pc_p4      = pc;
    i_res_src    = 2'b01;
  endtask

  task automatic idle_in();
    i_valid     = 1'b0;
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    i_alu_result = '0; i_store_data = '0; i_funct3 = '0;
    i_res_src = '0; i_pc_p4 = '0; i_rd = '0;
    i_bus_ack = 1'b0; i_bus_err = 1'b0; i_bus_rdata = '0;
    tick(); tick();
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_req",   32'(o_bus_req), 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    chk("rst_data",  o_data, 32'd0);
    rst = 1'b0;
    tick();

    // LW 0x100, three wait states then ack (ack lands on the timeout cycle)
    drive(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 5'd5, 30'h40);
    tick();
    idle_in();
    chk("lw_req",   32'(o_bus_req), 32'd1);
    chk("lw_we",    32'(o_bus_we), 32'd0);
    chk("lw_sel",   32'(o_bus_sel), 32'hF);
    chk("lw_addr",  32'(o_bus_addr), 32'h40);
    chk("lw_ready", 32'(o_ready), 32'd0);
    tick(); tick();
    chk("lw_wait_valid", 32'(o_valid), 32'd0);
    chk("lw_wait_req",   32'(o_bus_req), 32'd1);
    tick();
    i_bus_ack = 1'b1; i_bus_rdata = 32'hDEADBEEF;
    tick();
    i_bus_ack = 1'b0;
    chk("lw_valid", 32'(o_valid), 32'd1);
    chk("lw_data",  o_data, 32'hDEADBEEF);
    chk("lw_rd",    32'(o_rd), 32'd5);
    chk("lw_fault", 32'(o_fault), 32'd0);
    chk("lw_pc",    32'(o_pc_p4), 32'h40);
    chk("lw_req_off", 32'(o_bus_req), 32'd0);
    chk("lw_sel_idle", 32'(o_bus_sel), 32'd0);
    tick();
    chk("lw_pulse", 32'(o_valid), 32'd0);
    chk("lw_hold",  o_data, 32'hDEADBEEF);

    // SB 0x203
    drive(1'b0, 1'b1, 32'h203, 32'h000000A5, 3'b000, 5'd7, 30'h41);
    tick();
    idle_in();
    chk("sb_sel",   32'(o_bus_sel), 32'h8);
    chk("sb_wdata", o_bus_wdata, 32'hA5A5A5A5);
    chk("sb_we",    32'(o_bus_we), 32'd1);
    chk("sb_addr",  32'(o_bus_addr), 32'h80);
    i_bus_ack = 1'b1;
    tick();
    i_bus_ack = 1'b0;
    chk("sb_valid", 32'(o_valid), 32'd1);
    chk("sb_rd",    32'(o_rd), 32'd0);
    chk("sb_data",  o_data, 32'd0);

    // SH 0x202
    drive(1'b0, 1'b1, 32'h202, 32'h00001234, 3'b001, 5'd8, 30'h42);
    tick();
    idle_in();
    chk("sh_sel",   32'(o_bus_sel), 32'hC);
    chk("sh_wdata", o_bus_wdata, 32'h12341234);
    i_bus_ack = 1'b1;
    tick();
    i_bus_ack = 1'b0;
    chk("sh_valid", 32'(o_valid), 32'd1);

    // LH 0x101 misaligned
    drive(1'b1, 1'b0, 32'h101, 32'h0, 3'b001, 5'd3, 30'h43);
    tick();
    idle_in();
    chk("lh_req",   32'(o_bus_req), 32'd0);
    chk("lh_valid", 32'(o_valid), 32'd1);
    chk("lh_fault", 32'(o_fault), 32'd1);
    chk("lh_rd",    32'(o_rd), 32'd0);
    chk("lh_ready", 32'(o_ready), 32'd1);

    // LW with no ack: TIMEOUT=4 gives four request cycles
    drive(1'b1, 1'b0, 32'h300, 32'h0, 3'b010, 5'd6, 30'h44);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(o_bus_req), 32'd1);
      tick();
    end
    chk("to_req_off", 32'(o_bus_req), 32'd0);
    chk("to_valid",   32'(o_valid), 32'd1);
    chk("to_fault",   32'(o_fault), 32'd3);
    chk("to_rd",      32'(o_rd), 32'd0);

    // err and ack together
    drive(1'b1, 1'b0, 32'h104, 32'h0, 3'b010, 5'd9, 30'h45);
    tick();
    idle_in();
    i_bus_ack = 1'b1; i_bus_err = 1'b1; i_bus_rdata = 32'h55555555;
    tick();
    i_bus_ack = 1'b0; i_bus_err = 1'b0;
    chk("err_valid", 32'(o_valid), 32'd1);
    chk("err_fault", 32'(o_fault), 32'd2);
    chk("err_rd",    32'(o_rd), 32'd0);

    // reset in the middle of a bus access
    drive(1'b1, 1'b0, 32'h108, 32'h0, 3'b010, 5'd10, 30'h46);
    tick();
    idle_in();
    chk("mr_req_on", 32'(o_bus_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mr_req_async", 32'(o_bus_req), 32'd0);
    chk("mr_ready",     32'(o_ready), 32'd1);
    tick();
    rst = 1'b0;
    chk("mr_valid0", 32'(o_valid), 32'd0);
    tick();
    chk("mr_valid1", 32'(o_valid), 32'd0);

    // ADD, LW, ADD back to back
    drive(1'b0, 1'b0, 32'h11, 32'h0, 3'b000, 5'd1, 30'h50);
    tick();
    chk("b1_valid", 32'(o_valid), 32'd1);
    chk("b1_rd",    32'(o_rd), 32'd1);
    chk("b1_alu",   o_alu_result, 32'h11);
    chk("b1_data",  o_data, 32'd0);
    chk("b1_ready", 32'(o_ready), 32'd1);
    drive(1'b1, 1'b0, 32'h200, 32'h0, 3'b010, 5'd4, 30'h51);
    tick();
    chk("b2_ready", 32'(o_ready), 32'd0);
    chk("b2_valid", 32'(o_valid), 32'd0);
    chk("b2_hold",  32'(o_rd), 32'd1);
    drive(1'b0, 1'b0, 32'h22, 32'h0, 3'b000, 5'd2, 30'h52);
    i_bus_ack = 1'b1; i_bus_rdata = 32'hCAFEF00D;
    tick();
    i_bus_ack = 1'b0;
    chk("b2_valid_out", 32'(o_valid), 32'd1);
    chk("b2_rd",        32'(o_rd), 32'd4);
    chk("b2_data",      o_data, 32'hCAFEF00D);
    chk("b2_ready_back", 32'(o_ready), 32'd1);
    tick();
    idle_in();
    chk("b3_valid", 32'(o_valid), 32'd1);
    chk("b3_rd",    32'(o_rd), 32'd2);
    chk("b3_alu",   o_alu_result, 32'h22);
    chk("b3_data",  o_data, 32'd0);
    tick();
    chk("b3_pulse", 32'(o_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
